// File: rtl/mem_req_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the memory port.
interface mem_req_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              m0_req_valid;
  logic              m0_req_ready;
  logic [ADDR_W-1:0] m0_req_addr;
  logic              m0_resp_valid;
  logic [DATA_W-1:0] m0_resp_rdata;

  logic              m1_req_valid;
  logic              m1_req_ready;
  logic [ADDR_W-1:0] m1_req_addr;
  logic              m1_req_we;
  logic [DATA_W-1:0] m1_req_wdata;
  logic [STRB_W-1:0] m1_req_wstrb;
  logic              m1_resp_valid;
  logic [DATA_W-1:0] m1_resp_rdata;

  logic              s_req_valid;
  logic              s_req_ready;
  logic [ADDR_W-1:0] s_req_addr;
  logic              s_req_we;
  logic [DATA_W-1:0] s_req_wdata;
  logic [STRB_W-1:0] s_req_wstrb;
  logic              s_resp_valid;
  logic [DATA_W-1:0] s_resp_rdata;

  logic              busy;

  // Arbiter side.
  modport slave (
    input  m0_req_valid, m0_req_addr,
    input  m1_req_valid, m1_req_addr, m1_req_we, m1_req_wdata, m1_req_wstrb,
    input  s_req_ready, s_resp_valid, s_resp_rdata,
    output m0_req_ready, m0_resp_valid, m0_resp_rdata,
    output m1_req_ready, m1_resp_valid, m1_resp_rdata,
    output s_req_valid, s_req_addr, s_req_we, s_req_wdata, s_req_wstrb,
    output busy
  );

  // Requester and memory side.
  modport master (
    output m0_req_valid, m0_req_addr,
    output m1_req_valid, m1_req_addr, m1_req_we, m1_req_wdata, m1_req_wstrb,
    output s_req_ready, s_resp_valid, s_resp_rdata,
    input  m0_req_ready, m0_resp_valid, m0_resp_rdata,
    input  m1_req_ready, m1_resp_valid, m1_resp_rdata,
    input  s_req_valid, s_req_addr, s_req_we, s_req_wdata, s_req_wstrb,
    input  busy
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between fetch (m0) and load/store (m1), one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin on contention; default is fixed priority m1 over m0.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic              i_clk,
  input logic              i_rstn,
  mem_req_arbiter_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  logic [1:0]        state_q, state_d;
  logic              owner_q;
  req_t              req_q, req_sel;
  logic              prio_m1, grant_m1, accept;
  logic              s_req_valid_q, busy_q;
  logic              m0_resp_valid_q, m1_resp_valid_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

`ifdef MEM_ARB_RR_EN
  // Last-grant pointer: 1 = m1 granted last; a tie goes to the other requester.
  logic last_m1_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)     last_m1_q <= 1'b0;
    else if (accept) last_m1_q <= grant_m1;
  end

  assign prio_m1 = ~last_m1_q;
`else
  assign prio_m1 = 1'b1;
`endif

  assign grant_m1 = bus.m1_req_valid & (~bus.m0_req_valid | prio_m1);
  assign accept   = (state_q == IDLE) & (bus.m0_req_valid | bus.m1_req_valid);

  assign bus.m0_req_ready = (state_q == IDLE) & bus.m0_req_valid & ~grant_m1;
  assign bus.m1_req_ready = (state_q == IDLE) & grant_m1;

  // Winner's request fields; m0 is always a read with no strobes.
  always_comb begin
    req_sel = '0;
    if (grant_m1) begin
      req_sel.addr  = bus.m1_req_addr;
      req_sel.we    = bus.m1_req_we;
      req_sel.wdata = bus.m1_req_wdata;
      req_sel.wstrb = bus.m1_req_wstrb;
    end else begin
      req_sel.addr  = bus.m0_req_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)           state_d = ISSUE;
      ISSUE:   if (bus.s_req_ready)  state_d = WAIT;
      WAIT:    if (bus.s_resp_valid) state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Registered outputs, derived from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      req_q           <= '0;
      owner_q         <= 1'b0;
      s_req_valid_q   <= 1'b0;
      busy_q          <= 1'b0;
      m0_resp_valid_q <= 1'b0;
      m1_resp_valid_q <= 1'b0;
      m0_rdata_q      <= '0;
      m1_rdata_q      <= '0;
    end else begin
      s_req_valid_q   <= (state_d == ISSUE);
      busy_q          <= (state_d != IDLE);
      m0_resp_valid_q <= 1'b0;
      m1_resp_valid_q <= 1'b0;
      if (accept) begin
        req_q   <= req_sel;
        owner_q <= grant_m1;
      end
      if ((state_q == WAIT) && bus.s_resp_valid) begin
        if (owner_q) begin
          m1_resp_valid_q <= 1'b1;
          m1_rdata_q      <= req_q.we ? DATA_W'(0) : bus.s_resp_rdata;
        end else begin
          m0_resp_valid_q <= 1'b1;
          m0_rdata_q      <= bus.s_resp_rdata;
        end
      end
    end
  end

  assign bus.s_req_valid   = s_req_valid_q;
  assign bus.s_req_addr    = req_q.addr;
  assign bus.s_req_we      = req_q.we;
  assign bus.s_req_wdata   = req_q.wdata;
  assign bus.s_req_wstrb   = req_q.wstrb;
  assign bus.m0_resp_valid = m0_resp_valid_q;
  assign bus.m0_resp_rdata = m0_rdata_q;
  assign bus.m1_resp_valid = m1_resp_valid_q;
  assign bus.m1_resp_rdata = m1_rdata_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized scoreboard bench for mem_req_arbiter with a transaction-level reference model.
module tb_mem_req_arbiter;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          gap;
  } cmd_t;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.i_clk(clk), .i_rstn(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cmd_t  m0_q[$], m1_q[$], exp_s[$];
  resp_t exp_r[$];
  bit    grant_log[$];
  cmd_t  m0_cur, m1_cur;
  bit    m0_act = 0, m0_pend = 0, m1_act = 0, m1_pend = 0;
  bit    last_m1 = 0;

  // Memory model controls: mode 0 random ready, 1 always ready, 2 ready after hold_n cycles.
  int    mem_mode = 1, hold_n = 0, lat_fix = 0;
  bit    spur_en = 0, pending = 0, orphan = 0;
  int    exp_pulse_cyc = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // m0 requester: holds valid until accepted, then moves its address away.
  initial begin : drv_m0
    bit acc;
    int wt;
    acc = 0; wt = 0;
    forever begin
      @(negedge clk);
      if (m0_act && acc) begin
        m0_act = 0;
        bus.m0_req_valid = 1'b0;
        bus.m0_req_addr  = m0_cur.addr + 32'h200;
      end
      if (!m0_act && !m0_pend && m0_q.size() > 0) begin
        m0_cur = m0_q.pop_front(); wt = m0_cur.gap; m0_pend = 1;
      end
      if (m0_pend) begin
        if (wt > 0) wt--;
        else begin
          m0_pend = 0; m0_act = 1;
          bus.m0_req_valid = 1'b1;
          bus.m0_req_addr  = m0_cur.addr;
        end
      end
      #1 acc = m0_act && bus.m0_req_ready;
    end
  end

  // m1 requester: same protocol, scrambles all fields after accept.
  initial begin : drv_m1
    bit acc;
    int wt;
    acc = 0; wt = 0;
    forever begin
      @(negedge clk);
      if (m1_act && acc) begin
        m1_act = 0;
        bus.m1_req_valid = 1'b0;
        bus.m1_req_addr  = $urandom;
        bus.m1_req_we    = 1'($urandom);
        bus.m1_req_wdata = $urandom;
        bus.m1_req_wstrb = 4'($urandom);
      end
      if (!m1_act && !m1_pend && m1_q.size() > 0) begin
        m1_cur = m1_q.pop_front(); wt = m1_cur.gap; m1_pend = 1;
      end
      if (m1_pend) begin
        if (wt > 0) wt--;
        else begin
          m1_pend = 0; m1_act = 1;
          bus.m1_req_valid = 1'b1;
          bus.m1_req_addr  = m1_cur.addr;
          bus.m1_req_we    = m1_cur.we;
          bus.m1_req_wdata = m1_cur.wdata;
          bus.m1_req_wstrb = m1_cur.wstrb;
        end
      end
      #1 acc = m1_act && bus.m1_req_ready;
    end
  end

  // Memory port model: checks forwarded requests against the scoreboard and answers them.
  initial begin : mem_model
    cmd_t        cur;
    bit          have_cur, rdy;
    int          hold_cnt, lat_cnt;
    logic [31:0] pend_data;
    have_cur = 0; hold_cnt = 0; lat_cnt = 0; pend_data = '0;
    forever begin
      @(negedge clk);
      bus.s_req_ready  = 1'b0;
      bus.s_resp_valid = 1'b0;
      bus.s_resp_rdata = $urandom;
      if (pending) begin
        if (lat_cnt == 0) begin
          bus.s_resp_valid = 1'b1;
          bus.s_resp_rdata = pend_data;
          pending = 0;
          if (orphan) orphan = 0;
          else exp_pulse_cyc = cyc + 1;
        end else lat_cnt--;
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        bus.s_resp_valid = 1'b1;
      end
      if (!rst_n) have_cur = 0;
      else begin
        #1;
        if (bus.s_req_valid) begin
          if (!have_cur) begin
            if (exp_s.size() == 0) chk("s_req_valid_unexpected", 32'(bus.s_req_valid), 32'd0);
            else begin cur = exp_s.pop_front(); have_cur = 1; hold_cnt = 0; end
          end
          if (have_cur) begin
            chk("s_req_addr", bus.s_req_addr, cur.addr);
            chk("s_req_we", 32'(bus.s_req_we), 32'(cur.we));
            chk("s_req_wstrb", 32'(bus.s_req_wstrb), 32'(cur.wstrb));
            if (cur.we) chk("s_req_wdata", bus.s_req_wdata, cur.wdata);
            case (mem_mode)
              1:       rdy = 1;
              2:       rdy = (hold_cnt >= hold_n);
              default: rdy = 1'($urandom_range(0, 1));
            endcase
            hold_cnt++;
            if (rdy) begin
              bus.s_req_ready = 1'b1;
              pending   = 1;
              lat_cnt   = (lat_fix < 0) ? int'($urandom_range(0, 4)) : lat_fix;
              pend_data = cur.we ? $urandom : mem_word(bus.s_req_addr);
              have_cur  = 0;
            end
          end
        end else begin
          if (have_cur) chk("s_req_valid_dropped", 32'(bus.s_req_valid), 32'd1);
          if (mem_mode == 0) bus.s_req_ready = 1'($urandom_range(0, 1));
          else if (mem_mode == 1) bus.s_req_ready = 1'b1;
        end
      end
    end
  end

  // Response monitor: every requester response must match the oldest expectation.
  initial begin : resp_mon
    resp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (bus.m0_resp_valid || bus.m1_resp_valid) begin
          if (exp_r.size() == 0) begin
            chk("resp_unexpected_m0", 32'(bus.m0_resp_valid), 32'd0);
            chk("resp_unexpected_m1", 32'(bus.m1_resp_valid), 32'd0);
          end else begin
            e = exp_r.pop_front();
            chk("resp_valid_m0", 32'(bus.m0_resp_valid), 32'(!e.owner));
            chk("resp_valid_m1", 32'(bus.m1_resp_valid), 32'(e.owner));
            if (e.owner) chk("m1_resp_rdata", bus.m1_resp_rdata, e.rdata);
            else         chk("m0_resp_rdata", bus.m0_resp_rdata, e.rdata);
            chk("resp_cycle", 32'(cyc), 32'(exp_pulse_cyc));
          end
        end else if (cyc == exp_pulse_cyc) begin
          chk("resp_missing", 32'(bus.m0_resp_valid | bus.m1_resp_valid), 32'd1);
        end
      end
    end
  end

  // Arbitration model: one transaction at a time; ties resolved by priority rule.
  initial begin : arb_model
    bit idle, v0, v1, w;
    cmd_t  s;
    resp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        idle = (exp_r.size() == 0);
        v0 = bus.m0_req_valid;
        v1 = bus.m1_req_valid;
`ifdef MEM_ARB_RR_EN
        w = (v1 && !v0) || (v1 && v0 && !last_m1);
`else
        w = v1;
`endif
        chk("busy", 32'(bus.busy), 32'(!idle));
        chk("m0_req_ready", 32'(bus.m0_req_ready), 32'(idle && v0 && !w));
        chk("m1_req_ready", 32'(bus.m1_req_ready), 32'(idle && v1 && w));
        if (bus.m0_req_ready || bus.m1_req_ready) grant_log.push_back(bus.m1_req_ready);
        if (idle && (v0 || v1)) begin
          if (w) begin
            s = m1_cur;
            r.rdata = m1_cur.we ? 32'd0 : mem_word(m1_cur.addr);
          end else begin
            s = m0_cur; s.we = 0; s.wdata = '0; s.wstrb = '0;
            r.rdata = mem_word(m0_cur.addr);
          end
          r.owner = w;
          exp_s.push_back(s);
          exp_r.push_back(r);
          last_m1 = w;
        end
      end
    end
  end

  task automatic wait_done(input string nm, input int maxc);
    int n;
    n = 0;
    while ((m0_q.size() > 0 || m1_q.size() > 0 || m0_act || m0_pend || m1_act || m1_pend ||
            exp_r.size() > 0 || exp_s.size() > 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n < maxc), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    exp_r.delete(); exp_s.delete(); last_m1 = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic push_m0(input logic [31:0] a, input int gap);
    cmd_t c;
    c.addr = a; c.we = 0; c.wdata = '0; c.wstrb = '0; c.gap = gap;
    m0_q.push_back(c);
  endtask

  task automatic push_m1(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] ws, input int gap);
    cmd_t c;
    c.addr = a; c.we = we; c.wdata = wd; c.wstrb = ws; c.gap = gap;
    m1_q.push_back(c);
  endtask

  initial begin : main
    bit exp_ord[4];
    int n;
    bus.m0_req_valid = 0; bus.m0_req_addr = '0;
    bus.m1_req_valid = 0; bus.m1_req_addr = '0; bus.m1_req_we = 0;
    bus.m1_req_wdata = '0; bus.m1_req_wstrb = '0;
    bus.s_req_ready = 0; bus.s_resp_valid = 0; bus.s_resp_rdata = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_s_req_valid", 32'(bus.s_req_valid), 32'd0);
    chk("rst_s_req_addr", bus.s_req_addr, 32'd0);
    chk("rst_s_req_we", 32'(bus.s_req_we), 32'd0);
    chk("rst_s_req_wdata", bus.s_req_wdata, 32'd0);
    chk("rst_s_req_wstrb", 32'(bus.s_req_wstrb), 32'd0);
    chk("rst_m0_resp", 32'(bus.m0_resp_valid), 32'd0);
    chk("rst_m1_resp", 32'(bus.m1_resp_valid), 32'd0);
    chk("rst_m0_rdata", bus.m0_resp_rdata, 32'd0);
    chk("rst_m1_rdata", bus.m1_resp_rdata, 32'd0);
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Contention from reset: both requesters valid back to back.
    mem_mode = 1; lat_fix = 1;
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      push_m0(32'h1000 + 32'(i * 4), 0);
      push_m1(32'h2000 + 32'(i * 4), 0, 32'd0, 4'hF, 0);
    end
    wait_done("drain_contention", 400);
`ifdef MEM_ARB_RR_EN
    exp_ord = '{1, 0, 1, 0};
`else
    exp_ord = '{1, 1, 1, 1};
`endif
    chk("grant_log_len", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'(exp_ord[i]));

    // Single m0 read; address moves to 0x300 after accept.
    mem_mode = 1; lat_fix = 3;
    push_m0(32'h100, 0);
    wait_done("drain_m0_read", 100);

    // m1 write with memory ready held low for 4 cycles.
    mem_mode = 2; hold_n = 4; lat_fix = 2;
    push_m1(32'h200, 1, 32'h12345678, 4'hF, 0);
    wait_done("drain_m1_write", 100);

    // Spurious memory responses while idle or issuing.
    mem_mode = 0; lat_fix = 2; spur_en = 1;
    repeat (10) @(negedge clk);
    push_m0(32'h400, 0);
    push_m1(32'h500, 0, 32'd0, 4'h3, 1);
    wait_done("drain_spurious", 200);
    spur_en = 0;

    // Reset while waiting for the memory response.
    mem_mode = 1; lat_fix = 8;
    push_m0(32'h100, 0);
    n = 0;
    while (!pending && n < 50) begin @(negedge clk); n++; end
    chk("reset_setup", 32'(pending), 32'd1);
    repeat (2) @(negedge clk);
    #3;
    orphan = pending;
    rst_n = 1'b0;
    exp_r.delete(); exp_s.delete(); last_m1 = 0;
    #1;
    chk("rst_wait_busy", 32'(bus.busy), 32'd0);
    chk("rst_wait_s_req_valid", 32'(bus.s_req_valid), 32'd0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    n = 0;
    while (pending && n < 50) begin @(negedge clk); n++; end
    chk("orphan_resp_fired", 32'(pending), 32'd0);
    repeat (3) @(negedge clk);
    lat_fix = 1;
    push_m0(32'h100, 0);
    wait_done("drain_after_reset", 100);

    // Randomized traffic.
    do_reset();
    mem_mode = 0; lat_fix = -1; spur_en = 1;
    for (int i = 0; i < 150; i++) begin
      push_m0($urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)));
      push_m1($urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end
    wait_done("drain_random", 20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
